ex_stage_mdu: RTL and testbench
===============================

// Module: ex_stage_mdu
// PURPOSE
//  Execute stage of the 5-level pipeline. It consumes the ID->EX register outputs and computes the ALU/link result for the EX->MEM register.
//  It contains an iterative unsigned multiply/divide unit with HI/LO registers.
//  While a MULTU/DIVU is in progress it stalls the front end: stall_ex=1 drives enable=0 on the IF/ID and ID/EX registers.
//  While stalled it presents a bubble to EX->MEM.
// PARAMETERS
//  XLEN     32  datapath width; HI/LO width; MDU iteration count
//  CNT_W    5   MDU step counter width (2**CNT_W == XLEN)
// PORTS
//  clock      in   1     rising-edge clock
//  reset_0    in   1     reset, asynchronous, active-low
//  a_ex       in   XLEN  rs operand
//  b_ex       in   XLEN  rt operand / store data
//  imm_ex     in   XLEN  sign/zero-extended immediate; [10:6]=shamt
//  pc_ex      in   XLEN  link address (already PC+4 of the jal)
//  rw_ex      in   5     destination register
//  op_ex      in   4     ALU op (encoding below)
//  wreg_ex, wmem_ex, rmem_ex  in 1  GPR write / mem write / mem read
//  aluimm_ex  in   1     1: operand B = imm_ex
//  shift_ex   in   1     1: operand A = {0, imm_ex[10:6]}
//  jal_ex     in   1     1: result = pc_ex
//  alu_o      out  XLEN  result to EX->MEM
//  b_o        out  XLEN  store data (= b_ex)
//  rw_o       out  5     = rw_ex
//  wreg_o, wmem_o, rmem_o  out 1  input controls ANDed with ~stall_ex
//  stall_ex   out  1     1: hold IF/ID, ID/EX and PC
// BEHAVIOUR
//  Operand select: A = shift_ex ? shamt : a_ex; B = aluimm_ex ? imm_ex : b_ex.
//  Op encoding (result, all combinational): 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 LUI {B[15:0],16'h0}.
//  6 SLL B<<A[4:0]; 7 SRL; 8 SRA (arithmetic); 9 SLT signed (A<B)?1:0.
//  A MULTU; B DIVU; C MFHI; D MFLO; E,F reserved -> 0.
//  Result precedence: jal_ex=1 overrides op and gives alu_o=pc_ex.
//  A and B ops give alu_o=0.
//  ADD and SUB wrap modulo 2**XLEN; no overflow trap.
//  MDU FSM states are IDLE, BUSY and DONE. Registers: hi, lo, cnt, opnd_a, opnd_b, is_div.
//   IDLE: op_ex in {A,B} and jal_ex=0 -> latch a_ex/b_ex (never imm), cnt<=0, go to BUSY.
//         This cycle stall_ex=1.
//   BUSY: one radix-2 step per cycle.
//     MULTU: shift-add.
//     DIVU: restoring, unsigned.
//     When cnt==XLEN-1: write hi/lo, then go to DONE.
//     Otherwise cnt<=cnt+1.
//   DONE: stall_ex=0; the held op advances this cycle. Next state is IDLE unconditionally.
//     The op is not restarted even though op_ex is still A/B.
//  stall_ex = (IDLE & mdu op) | BUSY. It is asserted for XLEN+1 = 33 cycles, and the op leaves on cycle 34.
//  MULTU result: {hi,lo} = a*b, 64-bit unsigned product.
//  DIVU result: lo = a/b, hi = a%b.
//  Divide by zero: lo = all-ones, hi = dividend. No exception.
//  MFHI/MFLO read hi/lo combinationally. They see the new values when issued directly after MULTU/DIVU, because hi/lo update before DONE.
//  Bubble: while stall_ex=1, wreg_o, wmem_o and rmem_o are 0. alu_o is don't-care.
//  Reset (async, at any time, including mid-BUSY): state=IDLE, hi=lo=0, cnt=0, opnds=0.
//   The combinational outputs follow their inputs.
//   An op still presented after reset restarts with the full 33-cycle stall.
//  All paths other than the MDU have zero latency. Registered state is only the FSM, cnt, hi/lo and latched operands.
// TESTING
//  1) op=0, aluimm=1, a=5, imm=FFFFFFFD -> alu_o=2. stall_ex=0. wreg_o=wreg_ex.
//  2) op=6, shift=1, b=1, imm[10:6]=4 -> alu_o=16. Also op=8, b=80000000, sa=4 -> F8000000. Also op=9, a=FFFFFFFF, b=1 -> 1.
//  3) MULTU a=FFFFFFFF, b=2 -> stall_ex high exactly 33 cycles, wreg_o=0 meanwhile. Then hi=1, lo=FFFFFFFE. A following MFHI -> 1.
//  4) DIVU 100/7 -> lo=14, hi=2. DIVU 100/0 -> lo=FFFFFFFF, hi=100. Each gives a 33-cycle stall, with exactly one DONE cycle and no restart.
//  5) reset_0 pulsed low at BUSY cnt=10 -> stall_ex=0 immediately, hi=lo=0. On release with DIVU still presented -> a fresh 33-cycle stall and the correct result.
//  6) jal_ex=1 with op=A, pc_ex=00400010 -> alu_o=00400010. No stall; hi/lo unchanged.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// Execute stage: combinational ALU/link result plus an iterative unsigned
// multiply/divide unit with HI/LO that stalls the front end while it runs.
module ex_stage_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clock,
  input  logic            reset_0,
  input  logic [XLEN-1:0] a_ex,
  input  logic [XLEN-1:0] b_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [4:0]      rw_ex,
  input  logic [3:0]      op_ex,
  input  logic            wreg_ex,
  input  logic            wmem_ex,
  input  logic            rmem_ex,
  input  logic            aluimm_ex,
  input  logic            shift_ex,
  input  logic            jal_ex,
  output logic [XLEN-1:0] alu_o,
  output logic [XLEN-1:0] b_o,
  output logic [4:0]      rw_o,
  output logic            wreg_o,
  output logic            wmem_o,
  output logic            rmem_o,
  output logic            stall_ex
);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_LUI   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_SLT   = 4'h9;
  localparam logic [3:0] OP_MULTU = 4'hA;
  localparam logic [3:0] OP_DIVU  = 4'hB;
  localparam logic [3:0] OP_MFHI  = 4'hC;
  localparam logic [3:0] OP_MFLO  = 4'hD;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  mdu_state_t        state_reg, state_next;
  logic [XLEN-1:0]   hi_reg, hi_next;
  logic [XLEN-1:0]   lo_reg, lo_next;
  logic [XLEN-1:0]   acc_reg, acc_next;
  logic [XLEN-1:0]   opnd_a_reg, opnd_a_next;
  logic [XLEN-1:0]   opnd_b_reg, opnd_b_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              is_div_reg, is_div_next;

  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   alu_res;
  logic              mdu_req;
  logic              slt_bit;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   acc_step;
  logic [XLEN-1:0]   opnd_a_step;

  // ---------------- operand select and ALU ----------------
  assign op_a    = shift_ex  ? XLEN'(imm_ex[10:6]) : a_ex;
  assign op_b    = aluimm_ex ? imm_ex : b_ex;
  assign slt_bit = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_res = '0;
    case (op_ex)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_LUI:  alu_res = XLEN'(op_b[15:0]) << 16;
      OP_SLL:  alu_res = op_b << op_a[CNT_W-1:0];
      OP_SRL:  alu_res = op_b >> op_a[CNT_W-1:0];
      OP_SRA:  alu_res = $signed(op_b) >>> op_a[CNT_W-1:0];
      OP_SLT:  alu_res = XLEN'(slt_bit);
      OP_MFHI: alu_res = hi_reg;
      OP_MFLO: alu_res = lo_reg;
      default: alu_res = '0;
    endcase
  end

  assign alu_o  = jal_ex ? pc_ex : alu_res;
  assign b_o    = b_ex;
  assign rw_o   = rw_ex;
  assign wreg_o = wreg_ex & ~stall_ex;
  assign wmem_o = wmem_ex & ~stall_ex;
  assign rmem_o = rmem_ex & ~stall_ex;

  // ---------------- multiply/divide unit ----------------
  assign mdu_req = ~jal_ex & ((op_ex == OP_MULTU) | (op_ex == OP_DIVU));

  // The reset gate keeps the front end free while reset is held.
  assign stall_ex = reset_0 & (((state_reg == IDLE) & mdu_req) | (state_reg == BUSY));

  // Multiply: {acc, opnd_a} is the running product, opnd_a shifts out the multiplier.
  assign mul_sum = {1'b0, acc_reg} + (opnd_a_reg[0] ? {1'b0, opnd_b_reg} : '0);
  // Divide: acc is the partial remainder, opnd_a shifts dividend out and quotient in.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
  assign div_shift = {acc_reg, opnd_a_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_b_reg};
  assign div_ge    = ~div_diff[XLEN];

  always_comb begin
    if (is_div_reg) begin
      acc_step    = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      opnd_a_step = {opnd_a_reg[XLEN-2:0], div_ge};
    end else begin
      acc_step    = mul_sum[XLEN:1];
      opnd_a_step = {mul_sum[0], opnd_a_reg[XLEN-1:1]};
    end
  end

  always_comb begin
    state_next  = state_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    acc_next    = acc_reg;
    opnd_a_next = opnd_a_reg;
    opnd_b_next = opnd_b_reg;
    cnt_next    = cnt_reg;
    is_div_next = is_div_reg;
    case (state_reg)
      IDLE: begin
        if (mdu_req) begin
          opnd_a_next = a_ex;
          opnd_b_next = b_ex;
          is_div_next = (op_ex == OP_DIVU);
          acc_next    = '0;
          cnt_next    = '0;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        acc_next    = acc_step;
        opnd_a_next = opnd_a_step;
        if (cnt_reg == CNT_W'(XLEN - 1)) begin
          hi_next    = acc_step;
          lo_next    = opnd_a_step;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      state_reg  <= IDLE;
      hi_reg     <= '0;
      lo_reg     <= '0;
      acc_reg    <= '0;
      opnd_a_reg <= '0;
      opnd_b_reg <= '0;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      acc_reg    <= acc_next;
      opnd_a_reg <= opnd_a_next;
      opnd_b_reg <= opnd_b_next;
      cnt_reg    <= cnt_next;
      is_div_reg <= is_div_next;
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Self-checking bench for ex_stage_mdu: directed and random ALU/MDU
// transactions against an arithmetic reference model of the execute stage.
module tb_ex_stage_mdu;

  logic        clock = 1'b0;
  logic        reset_0;
  logic [31:0] a_ex, b_ex, imm_ex, pc_ex;
  logic [4:0]  rw_ex;
  logic [3:0]  op_ex;
  logic        wreg_ex, wmem_ex, rmem_ex, aluimm_ex, shift_ex, jal_ex;
  logic [31:0] alu_o, b_o;
  logic [4:0]  rw_o;
  logic        wreg_o, wmem_o, rmem_o, stall_ex;

  int checks = 0;
  int passed = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_stage_mdu #(.XLEN(32), .CNT_W(5)) dut (
    .clock(clock), .reset_0(reset_0),
    .a_ex(a_ex), .b_ex(b_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
    .rw_ex(rw_ex), .op_ex(op_ex),
    .wreg_ex(wreg_ex), .wmem_ex(wmem_ex), .rmem_ex(rmem_ex),
    .aluimm_ex(aluimm_ex), .shift_ex(shift_ex), .jal_ex(jal_ex),
    .alu_o(alu_o), .b_o(b_o), .rw_o(rw_o),
    .wreg_o(wreg_o), .wmem_o(wmem_o), .rmem_o(rmem_o), .stall_ex(stall_ex)
  );

  always #5 clock = ~clock;

  // Reference: result of one instruction given the architectural HI/LO.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b, imm, pc,
                                          input logic aluimm, shift, jal);
    logic [31:0] x, y;
    logic [63:0] ext;
    int sx, sy;
    x = shift ? {27'd0, imm[10:6]} : a;
    y = aluimm ? imm : b;
    if (jal) return pc;
    case (op)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x & y;
      4'h3: return x | y;
      4'h4: return x ^ y;
      4'h5: return {y[15:0], 16'h0000};
      4'h6: return y << x[4:0];
      4'h7: return y >> x[4:0];
      4'h8: begin ext = {{32{y[31]}}, y} >> x[4:0]; return ext[31:0]; end
      4'h9: begin sx = x; sy = y; return (sx < sy) ? 32'd1 : 32'd0; end
      4'hC: return m_hi;
      4'hD: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void ref_mdu(input logic [3:0] op, input logic [31:0] a, b);
    logic [63:0] p;
    if (op == 4'hA) begin
      p = 64'(a) * 64'(b);
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (b == 32'd0) begin
      m_hi = a;
      m_lo = 32'hFFFF_FFFF;
    end else begin
      m_hi = a % b;
      m_lo = a / b;
    end
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, b, imm, pc,
                       input logic aluimm, shift, jal, input logic [2:0] ctl, input logic [4:0] rw);
    op_ex = op; a_ex = a; b_ex = b; imm_ex = imm; pc_ex = pc;
    aluimm_ex = aluimm; shift_ex = shift; jal_ex = jal;
    {wreg_ex, wmem_ex, rmem_ex} = ctl; rw_ex = rw;
  endtask

  task automatic test_reset;
    reset_0 = 1'b0;
    drive(4'hC, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'b100, 5'd3);
    repeat (2) @(negedge clock);
    #1;
    checks++; if (stall_ex !== 1'b0) $display("FAIL reset_stall got=%b want=0", stall_ex); else passed++;
    checks++; if (alu_o !== 32'd0) $display("FAIL reset_hi got=%h want=0", alu_o); else passed++;
    checks++; if (wreg_o !== 1'b1) $display("FAIL reset_wreg got=%b want=1", wreg_o); else passed++;
    op_ex = 4'hD; #1;
    checks++; if (alu_o !== 32'd0) $display("FAIL reset_lo got=%h want=0", alu_o); else passed++;
    @(negedge clock);
    reset_0 = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_directed;
    logic [31:0] imm;
    @(negedge clock);
    drive(4'h0, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 1'b1, 1'b0, 1'b0, 3'b100, 5'd7);
    #1;
    checks++; if (alu_o !== 32'd2) $display("FAIL add_imm got=%h want=2", alu_o); else passed++;
    checks++; if (stall_ex !== 1'b0) $display("FAIL add_stall got=%b want=0", stall_ex); else passed++;
    checks++; if (wreg_o !== 1'b1) $display("FAIL add_wreg got=%b want=1", wreg_o); else passed++;
    $display("txn add_imm alu_o=%h", alu_o);
    imm = 32'd4 << 6;
    @(negedge clock);
    drive(4'h6, 32'hDEAD_BEEF, 32'd1, imm, 32'd0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd1);
    #1;
    checks++; if (alu_o !== 32'd16) $display("FAIL sll got=%h want=10", alu_o); else passed++;
    $display("txn sll alu_o=%h", alu_o);
    @(negedge clock);
    drive(4'h8, 32'd0, 32'h8000_0000, imm, 32'd0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd1);
    #1;
    checks++; if (alu_o !== 32'hF800_0000) $display("FAIL sra got=%h want=f8000000", alu_o); else passed++;
    $display("txn sra alu_o=%h", alu_o);
    @(negedge clock);
    drive(4'h9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd1);
    #1;
    checks++; if (alu_o !== 32'd1) $display("FAIL slt got=%h want=1", alu_o); else passed++;
    $display("txn slt alu_o=%h", alu_o);
  endtask

  task automatic test_alu_random;
    logic [3:0]  op;
    logic [31:0] a, b, imm, pc, exp;
    logic        ai, sh, jl;
    logic [2:0]  ctl;
    logic [4:0]  rw;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom; imm = $urandom; pc = $urandom;
      ai = 1'($urandom); sh = 1'($urandom); jl = ($urandom_range(0, 7) == 0);
      if (op == 4'hA || op == 4'hB) jl = 1'b1;
      ctl = 3'($urandom); rw = 5'($urandom);
      @(negedge clock);
      drive(op, a, b, imm, pc, ai, sh, jl, ctl, rw);
      #1;
      exp = ref_alu(op, a, b, imm, pc, ai, sh, jl);
      checks++; if (alu_o !== exp) $display("FAIL rnd_alu op=%h got=%h want=%h", op, alu_o, exp); else passed++;
      checks++; if (stall_ex !== 1'b0) $display("FAIL rnd_stall op=%h got=%b want=0", op, stall_ex); else passed++;
      checks++; if ({wreg_o, wmem_o, rmem_o} !== ctl) $display("FAIL rnd_ctl got=%b want=%b", {wreg_o, wmem_o, rmem_o}, ctl); else passed++;
      checks++; if (b_o !== b || rw_o !== rw) $display("FAIL rnd_pass b_o=%h/%h rw_o=%0d/%0d", b_o, b, rw_o, rw); else passed++;
      $display("txn rnd op=%h jal=%b alu_o=%h", op, jl, alu_o);
    end
  endtask

  // Issue one MULTU/DIVU, measure the stall, then read HI and LO back.
  task automatic run_mdu(input logic [3:0] op, input logic [31:0] a, b);
    int n;
    bit bad;
    @(negedge clock);
    drive(op, a, b, $urandom, 32'd0, 1'b1, 1'b0, 1'b0, 3'b111, 5'd9);
    ref_mdu(op, a, b);
    #1;
    n = 0; bad = 0;
    while (stall_ex === 1'b1 && n < 100) begin
      n++;
      if ({wreg_o, wmem_o, rmem_o} !== 3'b000) bad = 1;
      @(negedge clock);
      #1;
    end
    checks++; if (n != 33) $display("FAIL mdu_stall_len op=%h got=%0d want=33", op, n); else passed++;
    checks++; if (bad) $display("FAIL mdu_bubble op=%h got=ctl_active want=000", op); else passed++;
    checks++; if ({wreg_o, wmem_o, rmem_o} !== 3'b111) $display("FAIL mdu_done_ctl got=%b want=111", {wreg_o, wmem_o, rmem_o}); else passed++;
    checks++; if (alu_o !== 32'd0) $display("FAIL mdu_done_alu got=%h want=0", alu_o); else passed++;
    @(negedge clock);
    drive(4'hC, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'b100, 5'd2);
    #1;
    checks++; if (stall_ex !== 1'b0) $display("FAIL mdu_restart got=%b want=0", stall_ex); else passed++;
    checks++; if (alu_o !== m_hi) $display("FAIL mfhi a=%h b=%h got=%h want=%h", a, b, alu_o, m_hi); else passed++;
    @(negedge clock);
    op_ex = 4'hD;
    #1;
    checks++; if (alu_o !== m_lo) $display("FAIL mflo a=%h b=%h got=%h want=%h", a, b, alu_o, m_lo); else passed++;
    $display("txn %s a=%h b=%h stall=%0d hi=%h lo=%h", (op == 4'hA) ? "multu" : "divu", a, b, n, m_hi, m_lo);
  endtask

  task automatic test_mdu;
    logic [31:0] a, b;
    run_mdu(4'hA, 32'hFFFF_FFFF, 32'd2);
    run_mdu(4'hB, 32'd100, 32'd7);
    run_mdu(4'hB, 32'd100, 32'd0);
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run_mdu((i % 2 == 0) ? 4'hA : 4'hB, a, b);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clock);
    drive(4'hB, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'b100, 5'd4);
    repeat (11) @(negedge clock);
    #2;
    reset_0 = 1'b0;
    #1;
    checks++; if (stall_ex !== 1'b0) $display("FAIL rst_mid_stall got=%b want=0", stall_ex); else passed++;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clock);
    op_ex = 4'hC; #1;
    checks++; if (alu_o !== 32'd0) $display("FAIL rst_mid_hi got=%h want=0", alu_o); else passed++;
    op_ex = 4'hD; #1;
    checks++; if (alu_o !== 32'd0) $display("FAIL rst_mid_lo got=%h want=0", alu_o); else passed++;
    op_ex = 4'hB;
    @(negedge clock);
    reset_0 = 1'b1;
    ref_mdu(4'hB, 32'd1000, 32'd3);
    #1;
    n = 0;
    while (stall_ex === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
      #1;
    end
    checks++; if (n != 33) $display("FAIL rst_restart_len got=%0d want=33", n); else passed++;
    @(negedge clock);
    op_ex = 4'hC; #1;
    checks++; if (alu_o !== m_hi) $display("FAIL rst_restart_hi got=%h want=%h", alu_o, m_hi); else passed++;
    op_ex = 4'hD; #1;
    checks++; if (alu_o !== m_lo) $display("FAIL rst_restart_lo got=%h want=%h", alu_o, m_lo); else passed++;
    $display("txn reset_mid_divu stall=%0d hi=%h lo=%h", n, m_hi, m_lo);
  endtask

  task automatic test_jal;
    @(negedge clock);
    drive(4'hA, 32'd77, 32'd55, 32'd0, 32'h0040_0010, 1'b0, 1'b0, 1'b1, 3'b100, 5'd31);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (alu_o !== 32'h0040_0010) $display("FAIL jal_alu got=%h want=00400010", alu_o); else passed++;
      checks++; if (stall_ex !== 1'b0) $display("FAIL jal_stall got=%b want=0", stall_ex); else passed++;
      @(negedge clock);
    end
    drive(4'hC, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0);
    #1;
    checks++; if (alu_o !== m_hi) $display("FAIL jal_hi got=%h want=%h", alu_o, m_hi); else passed++;
    op_ex = 4'hD; #1;
    checks++; if (alu_o !== m_lo) $display("FAIL jal_lo got=%h want=%h", alu_o, m_lo); else passed++;
    $display("txn jal alu_o=00400010 hi=%h lo=%h", m_hi, m_lo);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_alu_random;
    test_mdu;
    test_reset_mid;
    test_jal;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
